// File: rtl/id_ex_if.sv
// ID/EX pipeline register bus: decode-side inputs and EX-side registered outputs.
// master = decode stage / driver, slave = the ID/EX register itself.
`timescale 1ns/1ps
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid_i;
    logic [5:0]        id_opcode_i;
    logic [5:0]        id_funct_i;
    logic [1:0]        id_aluop_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              id_memwrite_i;
    logic              id_memtoreg_i;
    logic              id_alusrc_i;
    logic              id_regdst_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;

    logic              ex_valid_o;
    logic [5:0]        ex_opcode_o;
    logic [5:0]        ex_funct_o;
    logic [1:0]        ex_aluop_o;
    logic              ex_regwrite_o;
    logic              ex_memread_o;
    logic              ex_memwrite_o;
    logic              ex_memtoreg_o;
    logic              ex_alusrc_o;
    logic              ex_regdst_o;
    logic [DATA_W-1:0] ex_rs_data_o;
    logic [DATA_W-1:0] ex_rt_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_AW-1:0] ex_rs_o;
    logic [REG_AW-1:0] ex_rt_o;
    logic [REG_AW-1:0] ex_rd_o;

    modport master (
        output id_valid_i, id_opcode_i, id_funct_i, id_aluop_i,
               id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               id_alusrc_i, id_regdst_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i,
        input  ex_valid_o, ex_opcode_o, ex_funct_o, ex_aluop_o,
               ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
               ex_alusrc_o, ex_regdst_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o
    );

    modport slave (
        input  id_valid_i, id_opcode_i, id_funct_i, id_aluop_i,
               id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               id_alusrc_i, id_regdst_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i,
        output ex_valid_o, ex_opcode_o, ex_funct_o, ex_aluop_o,
               ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
               ex_alusrc_o, ex_regdst_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall handling and optional load-use hazard
// detection, enabled by defining IDEX_HAZARD_DETECT_EN.
`timescale 1ns/1ps
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall_i,
    input  logic   flush_i,
    output logic   stall_o,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [1:0]        aluop;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              alusrc;
        logic              regdst;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_d;
    logic hazard;

`ifdef IDEX_HAZARD_DETECT_EN
    // A bubble or a $0 destination can never create a dependency.
    assign hazard = ex_q.valid & ex_q.memread & bus.id_valid_i &
                    (ex_q.rt != '0) &
                    ((ex_q.rt == bus.id_rs_i) | (ex_q.rt == bus.id_rt_i));
`else
    assign hazard = 1'b0;
`endif

    assign stall_o = hazard & ~rst & ~flush_i;

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            // Control bits are masked when decode has nothing valid to hand over.
            ex_d.valid    = bus.id_valid_i;
            ex_d.opcode   = bus.id_opcode_i;
            ex_d.funct    = bus.id_funct_i;
            ex_d.aluop    = bus.id_aluop_i;
            ex_d.regwrite = bus.id_regwrite_i & bus.id_valid_i;
            ex_d.memread  = bus.id_memread_i  & bus.id_valid_i;
            ex_d.memwrite = bus.id_memwrite_i & bus.id_valid_i;
            ex_d.memtoreg = bus.id_memtoreg_i & bus.id_valid_i;
            ex_d.alusrc   = bus.id_alusrc_i   & bus.id_valid_i;
            ex_d.regdst   = bus.id_regdst_i   & bus.id_valid_i;
            ex_d.rs_data  = bus.id_rs_data_i;
            ex_d.rt_data  = bus.id_rt_data_i;
            ex_d.imm      = bus.id_imm_i;
            ex_d.rs       = bus.id_rs_i;
            ex_d.rt       = bus.id_rt_i;
            ex_d.rd       = bus.id_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid_o    = ex_q.valid;
    assign bus.ex_opcode_o   = ex_q.opcode;
    assign bus.ex_funct_o    = ex_q.funct;
    assign bus.ex_aluop_o    = ex_q.aluop;
    assign bus.ex_regwrite_o = ex_q.regwrite;
    assign bus.ex_memread_o  = ex_q.memread;
    assign bus.ex_memwrite_o = ex_q.memwrite;
    assign bus.ex_memtoreg_o = ex_q.memtoreg;
    assign bus.ex_alusrc_o   = ex_q.alusrc;
    assign bus.ex_regdst_o   = ex_q.regdst;
    assign bus.ex_rs_data_o  = ex_q.rs_data;
    assign bus.ex_rt_data_o  = ex_q.rt_data;
    assign bus.ex_imm_o      = ex_q.imm;
    assign bus.ex_rs_o       = ex_q.rs;
    assign bus.ex_rt_o       = ex_q.rt;
    assign bus.ex_rd_o       = ex_q.rd;

endmodule
